// File: rtl/pb_input_conditioner_pkg.sv
// Shared constants and debounce helpers for the pushbutton input conditioner.
// Values mirror the uP-wide PB_WIDTH / PB_DEBOUNCE / PB_CNT_W definitions.
package pb_input_conditioner_pkg;

  localparam int PB_WIDTH    = 4;
  localparam int PB_DEBOUNCE = 16;
  localparam int PB_CNT_W    = 4;

  typedef enum logic [1:0] {
    DB_HOLD   = 2'd0,
    DB_COUNT  = 2'd1,
    DB_ACCEPT = 2'd2
  } db_action_e;

  // Decide what the debounce counter does with one synchronized sample.
  function automatic db_action_e db_action(input logic sample,
                                           input logic stable,
                                           input logic at_max);
    db_action_e act;
    if (sample == stable) begin
      act = DB_HOLD;
    end else if (at_max) begin
      act = DB_ACCEPT;
    end else begin
      act = DB_COUNT;
    end
    return act;
  endfunction

endpackage

// File: rtl/pb_input_conditioner_if.sv
// Button-side bus of the input conditioner: raw buttons and read strobe in,
// conditioned values out.
interface pb_input_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic             rd_strobe;
  logic [WIDTH-1:0] pushbuttons;
  logic [WIDTH-1:0] btn_level;
  logic             btn_pending;

  modport master (
    output btn_raw,
    output rd_strobe,
    input  pushbuttons,
    input  btn_level,
    input  btn_pending
  );

  modport slave (
    input  btn_raw,
    input  rd_strobe,
    output pushbuttons,
    output btn_level,
    output btn_pending
  );
endinterface

// File: rtl/pb_input_conditioner_debounce_cell.sv
// One button bit: 2-flop synchronizer, counter debouncer and a registered
// one-cycle rise pulse that is high in the first cycle level_o reads 1.
module pb_debounce_cell
  import pb_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE,
  parameter int CNT_W           = PB_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  db_action_e       action_s;

  // Synchronizer chain for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter only runs while the sample disagrees; the compare at CNT_MAX bounds it.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    action_s = db_action(sync2_q, stable_q, (cnt_q == CNT_MAX));
    case (action_s)
      DB_HOLD: begin
        cnt_d = '0;
      end
      DB_COUNT: begin
        cnt_d = cnt_q + CNT_ONE;
      end
      DB_ACCEPT: begin
        cnt_d    = '0;
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pb_input_conditioner.sv
// Pushbutton conditioner feeding the uP input port: per-bit debounce cells plus
// an optional sticky press latch cleared by the IN read strobe (macro PB_STICKY_EN).
module pb_input_conditioner
  import pb_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = PB_WIDTH,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE,
  parameter int CNT_W           = PB_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  pb_input_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] rise_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    pb_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (bus.btn_raw[i]),
      .level_o (level_s[i]),
      .rise_o  (rise_s[i])
    );
  end

  assign bus.btn_level = level_s;

`ifdef PB_STICKY_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             pending_q, pending_d;

  // A new press outranks a read in the same cycle, so no event is lost.
  always_comb begin
    sticky_d  = rise_s | (sticky_q & ~{WIDTH{bus.rd_strobe}});
    pending_d = |sticky_d;
  end

  // Sticky press bits and their summary flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      sticky_q  <= sticky_d;
      pending_q <= pending_d;
    end
  end

  assign bus.pushbuttons = sticky_q;
  assign bus.btn_pending = pending_q;
`else
  logic unused_s;
  assign unused_s        = ^{rise_s, bus.rd_strobe};
  assign bus.pushbuttons = level_s;
  assign bus.btn_pending = 1'b0;
`endif

endmodule
